// File: rtl/mem_access_unit_pkg.sv
// Shared types for the handshaked memory port: address source, access size
// (funct3 encoding) and the port sequencer states.
package mem_access_unit_pkg;

  typedef enum logic {
    ADR_SRC__PC     = 1'b0,
    ADR_SRC__RESULT = 1'b1
  } adr_src_t;

  typedef enum logic [2:0] {
    MEM_SIZE__B   = 3'b000,
    MEM_SIZE__H   = 3'b001,
    MEM_SIZE__W   = 3'b010,
    MEM_SIZE__D   = 3'b011,
    MEM_SIZE__BU  = 3'b100,
    MEM_SIZE__HU  = 3'b101,
    MEM_SIZE__WU  = 3'b110,
    MEM_SIZE__BAD = 3'b111
  } mem_size_t;

  typedef enum logic [1:0] {
    MAU__IDLE   = 2'b00,
    MAU__ACCESS = 2'b01,
    MAU__DONE   = 2'b10
  } mau_state_t;

  // Number of bytes moved by an access; 0 marks an encoding with no size.
  function automatic logic [3:0] size_bytes(input mem_size_t size);
    case (size)
      MEM_SIZE__B, MEM_SIZE__BU: size_bytes = 4'd1;
      MEM_SIZE__H, MEM_SIZE__HU: size_bytes = 4'd2;
      MEM_SIZE__W, MEM_SIZE__WU: size_bytes = 4'd4;
      MEM_SIZE__D:               size_bytes = 4'd8;
      default:                   size_bytes = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load lane select plus sign/zero extension, purely combinational.
module load_extend
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]           raw,
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  mem_size_t                 size,
  output logic [XLEN-1:0]           data
);

  logic [XLEN-1:0] shifted_s;

  // Bring the addressed lane down to bit 0, then widen from the access size
  always_comb begin
    shifted_s = raw >> {offset, 3'b000};
    data      = shifted_s;
    case (size)
      MEM_SIZE__B:  data = XLEN'($signed(shifted_s[7:0]));
      MEM_SIZE__BU: data = XLEN'(shifted_s[7:0]);
      MEM_SIZE__H:  data = XLEN'($signed(shifted_s[15:0]));
      MEM_SIZE__HU: data = XLEN'(shifted_s[15:0]);
      MEM_SIZE__W:  data = XLEN'($signed(shifted_s[31:0]));
      MEM_SIZE__WU: data = XLEN'(shifted_s[31:0]);
      default:      data = shifted_s;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Handshaked fetch/load/store port with byte enables and misalignment faults.
// Optional wait-state timeout is enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  adr_src_t             adr_src,
  input  logic [ADDR_W-1:0]    pc,
  input  logic [ADDR_W-1:0]    result,
  input  logic                 we,
  input  logic [2:0]           funct3,
  input  logic [XLEN-1:0]      wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 fault,
  output logic [XLEN-1:0]      rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [XLEN/8-1:0]    mem_be,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic                 mem_ready,
  input  logic [XLEN-1:0]      mem_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  mau_state_t       state_r;
  mem_size_t        size_r;
  logic [OFF_W-1:0] off_r;
  logic [XLEN-1:0]  ext_s;

  logic [ADDR_W-1:0] adr_s;
  mem_size_t         size_s;
  logic              we_s;
  logic [3:0]        nbytes_s;
  logic [OFF_W-1:0]  off_s;
  logic              illegal_s;
  logic              misalign_s;
  logic [NB-1:0]     be_s;
  logic [XLEN-1:0]   wdata_s;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_r;
`endif

  // Decode the incoming request; only consumed on an accepted start
  always_comb begin
    adr_s = (adr_src == ADR_SRC__PC) ? pc : result;
    if (adr_src == ADR_SRC__PC) begin
      size_s = (XLEN == 64) ? MEM_SIZE__WU : MEM_SIZE__W;
      we_s   = 1'b0;
    end else begin
      size_s = mem_size_t'(funct3);
      we_s   = we;
    end
    nbytes_s = size_bytes(size_s);
    off_s    = adr_s[OFF_W-1:0];
    case (size_s)
      MEM_SIZE__D, MEM_SIZE__WU: illegal_s = (XLEN == 32);
      MEM_SIZE__BAD:             illegal_s = 1'b1;
      default:                   illegal_s = 1'b0;
    endcase
    misalign_s = (adr_s[2:0] & (nbytes_s[2:0] - 3'd1)) != 3'b000;
    be_s    = '0;
    wdata_s = '0;
    for (int i = 0; i < NB; i++) begin
      be_s[i] = (i >= int'(off_s)) && (i < int'(off_s) + int'(nbytes_s));
      // nbytes is a power of two, so masking the lane index repeats the store datum
      wdata_s[8*i +: 8] = wdata[8*(i & (int'(nbytes_s) - 1)) +: 8];
    end
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .raw    (mem_rdata),
    .offset (off_r),
    .size   (size_r),
    .data   (ext_s)
  );

  // Port sequencer with every output registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= MAU__IDLE;
      size_r    <= MEM_SIZE__B;
      off_r     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      tmo_cnt_r <= '0;
`endif
    end else begin
      case (state_r)
        MAU__ACCESS: begin
          if (mem_ready) begin
            state_r <= MAU__DONE;
            rdata   <= ext_s;
            done    <= 1'b1;
            fault   <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
          end else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1)) begin
            state_r <= MAU__DONE;
            done    <= 1'b1;
            fault   <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
`endif
          end
        end
        default: begin
          if (start) begin
            size_r <= size_s;
            off_r  <= off_s;
            busy   <= 1'b1;
            if (illegal_s || misalign_s) begin
              state_r <= MAU__DONE;
              done    <= 1'b1;
              fault   <= 1'b1;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
            end else begin
              state_r   <= MAU__ACCESS;
              done      <= 1'b0;
              fault     <= 1'b0;
              mem_req   <= 1'b1;
              mem_we    <= we_s;
              mem_addr  <= {adr_s[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_be    <= be_s;
              mem_wdata <= wdata_s;
`ifdef MEM_ACCESS_TIMEOUT_EN
              tmo_cnt_r <= '0;
`endif
            end
          end else begin
            state_r <= MAU__IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            fault   <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a bus responder and a completion monitor
// check the DUT against an arithmetic reference model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int XLEN = 32, ADDR_W = 32, NB = XLEN / 8, TIMEOUT_CYC = 4;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, we = 1'b0;
  adr_src_t adr_src = ADR_SRC__PC;
  logic [ADDR_W-1:0] pc = '0, result = '0;
  logic [2:0] funct3 = 3'b000;
  logic [XLEN-1:0] wdata = '0;
  logic busy, done, fault, mem_req, mem_we;
  logic [XLEN-1:0] rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [NB-1:0] mem_be;
  logic mem_ready = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset), .start(start), .adr_src(adr_src), .pc(pc), .result(result),
    .we(we), .funct3(funct3), .wdata(wdata), .busy(busy), .done(done), .fault(fault),
    .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [NB-1:0]     be;
    logic [XLEN-1:0]   wdata;
    logic              we;
    logic [XLEN-1:0]   rd;
    int                waits;
  } bus_t;

  typedef struct {
    logic            fault;
    logic [XLEN-1:0] rdata;
    logic            tmo;
  } done_t;

  bus_t  q_bus[$];
  done_t q_done[$];
  int n_pass = 0, n_total = 0, cyc = 0, req_rise = 0;
  logic [XLEN-1:0] model_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: sizes, lanes and extension worked out with plain arithmetic.
  task automatic model(input bit src_pc, input logic [ADDR_W-1:0] a, input logic we_v,
                       input logic [2:0] f3_in, input logic [XLEN-1:0] wd, input logic [XLEN-1:0] rd,
                       input int waits, output bus_t b, output done_t d, output bit bus_used,
                       output int lat);
    int bytes, off;
    logic [2:0] f;
    bit legal, sgn;
    logic [127:0] m, v, rep;
    f = src_pc ? ((XLEN == 64) ? 3'd6 : 3'd2) : f3_in;
    bytes = 1 << f[1:0];
    sgn = !src_pc && !f[2];
    legal = (f != 3'd7) && !(XLEN == 32 && (f == 3'd3 || f == 3'd6));
    off = int'(a % NB);
    bus_used = legal && (a % bytes == 0);
    m = (128'd1 << (8 * bytes)) - 128'd1;
    rep = '0;
    for (int j = 0; j * bytes < NB; j++) rep = rep | ((128'(wd) & m) << (8 * bytes * j));
    b.addr  = a - ADDR_W'(off);
    b.be    = NB'(((1 << bytes) - 1) << off);
    b.wdata = XLEN'(rep);
    b.we    = !src_pc && we_v;
    b.rd    = rd;
    b.waits = waits;
    v = (128'(rd) >> (8 * off)) & m;
    if (sgn && v[8*bytes-1]) v = v - (128'd1 << (8 * bytes));
    d.tmo = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    d.tmo = bus_used && (waits >= TIMEOUT_CYC);
`endif
    d.fault = !bus_used || d.tmo;
    if (!d.fault) model_rdata = XLEN'(v);
    d.rdata = model_rdata;
    lat = !bus_used ? 1 : (d.tmo ? 1 + TIMEOUT_CYC : 2 + waits);
  endtask

  task automatic chk_bus(input bus_t e);
    chk("bus_req", 64'(mem_req), 64'(1));
    chk("bus_addr", 64'(mem_addr), 64'(e.addr));
    chk("bus_be", 64'(mem_be), 64'(e.be));
    chk("bus_we", 64'(mem_we), 64'(e.we));
    if (e.we) chk("bus_wdata", 64'(mem_wdata), 64'(e.wdata));
  endtask

  task automatic issue(input bit src_pc, input logic [ADDR_W-1:0] a, input logic we_v,
                       input logic [2:0] f3, input logic [XLEN-1:0] wd, input logic [XLEN-1:0] rd,
                       input int waits, input int idle);
    bus_t b; done_t d; bit bus_used; int exp_lat, lat;
    repeat (idle) @(negedge clk);
    model(src_pc, a, we_v, f3, wd, rd, waits, b, d, bus_used, exp_lat);
    if (bus_used) q_bus.push_back(b);
    q_done.push_back(d);
    adr_src = src_pc ? ADR_SRC__PC : ADR_SRC__RESULT;
    pc      = src_pc ? a : ADDR_W'($urandom);
    result  = src_pc ? ADDR_W'($urandom) : a;
    we = we_v; funct3 = f3; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("req_after_start", 64'(mem_req), 64'(bus_used));
    chk("busy_after_start", 64'(busy), 64'(1));
    lat = 1;
    while (!done && lat < 200) begin
      start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("latency", 64'(lat), 64'(exp_lat));
  endtask

  // Bus responder: checks the request, holds it for the planned wait states, then completes it
  initial begin : responder
    bus_t e; int n; bit aborted;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        req_rise = cyc;
        mem_ready = 1'b0;
        if (q_bus.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_req: got mem_req=1 at addr 0x%0h, expected no request", mem_addr);
        end else begin
          e = q_bus.pop_front();
          n = 0; aborted = 1'b0;
          while (!aborted && n < e.waits) begin
            chk_bus(e);
            @(negedge clk);
            n++;
            if (!mem_req) aborted = 1'b1;
          end
          if (!aborted) begin
            chk_bus(e);
            mem_ready = 1'b1; mem_rdata = e.rd;
            @(negedge clk);
            mem_ready = 1'b0; mem_rdata = XLEN'($urandom);
            chk("req_drop", 64'(mem_req), 64'(0));
          end
        end
      end else begin
        mem_ready = ($urandom_range(0, 3) == 0);
        mem_rdata = XLEN'($urandom);
      end
    end
  end

  // Completion monitor: pops the expected result on every done pulse
  initial begin : monitor
    done_t d;
    forever begin
      @(negedge clk);
      if (done) begin
        if (q_done.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got done=1, expected no completion (t=%0t)", $time);
        end else begin
          d = q_done.pop_front();
          chk("fault", 64'(fault), 64'(d.fault));
          chk("rdata", 64'(rdata), 64'(d.rdata));
          chk("busy_in_done", 64'(busy), 64'(1));
          if (d.tmo) chk("tmo_latency", 64'(cyc - req_rise), 64'(TIMEOUT_CYC));
        end
      end
    end
  end

  initial begin : stimulus
    logic [ADDR_W-1:0] a;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_fault", 64'(fault), 64'(0));
    chk("rst_req", 64'({mem_req, mem_we}), 64'(0));
    chk("rst_bus", {mem_addr, mem_wdata}, 64'(0));
    chk("rst_be_rdata", 64'({mem_be, rdata}), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    issue(1'b1, 32'h100, 1'b0, 3'b000, '0, 32'h00500093, 0, 0);
    chk("fetch_rdata", 64'(rdata), 64'h00500093);
    issue(1'b0, 32'h203, 1'b0, 3'b000, '0, 32'h80FFFFFF, 3, 1);
    chk("lb_rdata", 64'(rdata), 64'hFFFFFF80);
    issue(1'b0, 32'h203, 1'b0, 3'b100, '0, 32'h80FFFFFF, 3, 0);
    chk("lbu_rdata", 64'(rdata), 64'h00000080);
    issue(1'b0, 32'h102, 1'b1, 3'b001, 32'h1234ABCD, XLEN'($urandom), 1, 0);
    issue(1'b0, 32'h101, 1'b0, 3'b010, '0, XLEN'($urandom), 0, 0);
    issue(1'b0, 32'h40, 1'b0, 3'b111, '0, XLEN'($urandom), 0, 1);
`ifdef MEM_ACCESS_TIMEOUT_EN
    issue(1'b0, 32'h300, 1'b0, 3'b010, '0, XLEN'($urandom), 100, 0);
    issue(1'b0, 32'h304, 1'b0, 3'b010, '0, 32'hCAFEF00D, 3, 0);
`endif

    // Reset in the middle of a stalled access
    q_bus.push_back('{addr: 32'h40, be: 4'hF, wdata: '0, we: 1'b0, rd: '0, waits: 1000});
    adr_src = ADR_SRC__RESULT; result = 32'h40; funct3 = 3'b010; we = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_req", 64'(mem_req), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_rdata", 64'(rdata), 64'(0));
    model_rdata = '0;
    @(negedge clk);
    reset = 1'b0;
    issue(1'b0, 32'h44, 1'b0, 3'b001, '0, 32'h8001FFFF, 1, 1);

    for (int t = 0; t < 300; t++) begin
      a = ADDR_W'($urandom);
      if ($urandom_range(0, 1) == 1) a = a & ~ADDR_W'(7);
`ifdef MEM_ACCESS_TIMEOUT_EN
      issue($urandom_range(0, 3) == 0, a, 1'($urandom), 3'($urandom), XLEN'($urandom),
            XLEN'($urandom), $urandom_range(0, 5), $urandom_range(0, 2));
`else
      issue($urandom_range(0, 3) == 0, a, 1'($urandom), 3'($urandom), XLEN'($urandom),
            XLEN'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
`endif
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
